axi_rr_arbiter_2to1: RTL and testbench
======================================

# axi_rr_arbiter_2to1

Two-master to one-slave AXI4 arbiter placed in front of the shared AXI target memory. It lets a DMA master and a CPU master share the memory's single-outstanding port. The write path (AW/W/B) and read path (AR/R) are arbitrated independently, each round-robin, and each grant is locked for a whole burst. Responses are routed by the registered grant, and IDs pass through unmodified.

## Interface
- ADDR_W, 32, address width of all AW/AR buses
- DATA_W, 32, WDATA/RDATA width; WSTRB is DATA_W/8
- ID_W, 2, AWID/ARID/BID/RID width
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous, active-low reset
- S0_AW{ID,ADDR,LEN,SIZE,BURST,VALID} / S0_AWREADY  in / out  ID_W,ADDR_W,8,3,2,1 / 1  master 0 write address
- S0_W{DATA,STRB,LAST,VALID} / S0_WREADY  in / out  DATA_W,DATA_W/8,1,1 / 1  master 0 write data
- S0_B{ID,RESP,VALID} / S0_BREADY  out / in  ID_W,2,1 / 1  master 0 write response
- S0_AR{ID,ADDR,LEN,SIZE,BURST,VALID} / S0_ARREADY  in / out  as AW / 1  master 0 read address
- S0_R{ID,DATA,RESP,LAST,VALID} / S0_RREADY  out / in  ID_W,DATA_W,2,1,1 / 1  master 0 read data
- S1_*  same set as S0_*  master 1
- M_*  mirrored set (directions reversed)  single slave port to target memory

## Operation
- Write FSM states: WR_IDLE, WR_ADDR, WR_DATA, WR_RESP.
  - WR_IDLE: if either S*_AWVALID is high, register wgnt from the round-robin picker and go to WR_ADDR.
  - WR_ADDR: granted AW is muxed to M_AW*. On M_AWVALID&&M_AWREADY go to WR_DATA.
  - WR_DATA: granted W is muxed to M_W*. On the handshake with M_WLAST=1 go to WR_RESP.
  - WR_RESP: M_B* is routed to the granted S*_B*, and M_BREADY is taken from the granted S*_BREADY. On the B handshake go to WR_IDLE and set wlast_served=wgnt.
- Read FSM states: RD_IDLE, RD_ADDR, RD_DATA, with the same structure.
  - RD_DATA routes M_R* to the granted master.
  - RD_DATA exits on the R handshake with M_RLAST=1, then updates rlast_served.
- Round robin (per path):
  - If only one requester, grant it.
  - If both request, grant the one that is not last_served.
  - last_served resets to 1, so master 0 wins the first tie.
- Non-granted master and inactive channels:
  - Non-granted master: AWREADY/WREADY/BVALID (and AR/R equivalents) are held at 0. Its pending VALID waits.
  - All M_*VALID are 0 outside their active state.
  - M_*READY-derived S-side readies are 0 outside their active state.
- IDs, LEN, SIZE, BURST, STRB and RESP are passed through unchanged. The routing decision uses only the grant register, never the ID.
- Granted master deasserting AWVALID in WR_ADDR is a protocol violation. The FSM holds its state and no grant change occurs.
- W beats presented before the grant are not accepted: WREADY stays 0 until WR_DATA.
- Read and write paths may be granted to different masters simultaneously.

## Timing
- Reset values:
  - All FSMs are IDLE; wgnt=rgnt=0; last_served=1.
  - Every VALID and READY output is 0.
  - Data/ID outputs are 0 (mux select is inactive).
- Arbitration latency: a request sampled in IDLE at edge N gives M_AWVALID (or M_ARVALID) high after edge N, i.e. 1 cycle.
- All data paths are combinational muxes; no added beat latency in ADDR/DATA/RESP.
- Back-to-back bursts: one IDLE cycle is required between bursts on a path.
- ARESETn asserted mid-burst: outputs go to reset values immediately (asynchronously). Burst progress is discarded and not replayed.

## Structure
- Package axi_arb_pkg:
  - wr_state_t and rd_state_t enums.
  - AXI_RESP_OKAY/SLVERR constants.
  - Default width localparams.
- Sub-module axi_rr_grant (2 requests, last_served in, grant out). It is instantiated once per path; the FSMs own the registers.
- Top level: two FSMs, grant registers and channel muxes.

## Test plan
- S0 only: AWADDR=0x10, AWLEN=3, WDATA 0xA0..0xA3 → M sees 4 beats, M_WLAST on the 4th; S0 gets BRESP=00; S1 readies stay 0.
- Both AWVALID in the same cycle after reset → S0 granted first. S1 is granted on the IDLE cycle after S0's B handshake; S1's BID reaches only S1.
- Three consecutive contended write rounds → grant order S0, S1, S0.
- Concurrent: S1 read (ARLEN=1) while S0 writes → both proceed. RDATA/RLAST reach S1 only, with the same cycle counts as isolated runs.
- S1 holds RREADY=0 for 3 cycles mid-read → M_RREADY=0 for those cycles and the beat is not lost; RLAST is delivered after release.
- ARESETn pulsed during WR_DATA beat 2 of 4 → all VALID/READY are 0 immediately. After release, a fresh S1 request is granted (last_served=1 is restored, so S1 wins the first tie? No: tie goes to S0). The bench checks that a solo S1 request is granted within 1 cycle.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI round-robin arbiter.
// Holds the path state encodings, response codes and default bus widths.
package axi_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int ID_W_DEF   = 2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ADDR = 2'd1,
        WR_DATA = 2'd2,
        WR_RESP = 2'd3
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axi_rr_grant.sv
// Two-way round-robin picker: a grant of 1 selects master 1.
// Purely combinational; the owning FSM registers the result and the history.
module axi_rr_grant (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       gnt
);

    // A lone requester wins; on a tie the master not served last wins
    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_served;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_rr_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter with independent round-robin write and read paths.
// Each grant is held for a whole burst; responses follow the grant register, IDs pass through.
module axi_rr_arbiter_2to1
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = ID_W_DEF
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // master 0
    input  logic [ID_W-1:0]     S0_AWID,
    input  logic [ADDR_W-1:0]   S0_AWADDR,
    input  logic [7:0]          S0_AWLEN,
    input  logic [2:0]          S0_AWSIZE,
    input  logic [1:0]          S0_AWBURST,
    input  logic                S0_AWVALID,
    output logic                S0_AWREADY,
    input  logic [DATA_W-1:0]   S0_WDATA,
    input  logic [DATA_W/8-1:0] S0_WSTRB,
    input  logic                S0_WLAST,
    input  logic                S0_WVALID,
    output logic                S0_WREADY,
    output logic [ID_W-1:0]     S0_BID,
    output logic [1:0]          S0_BRESP,
    output logic                S0_BVALID,
    input  logic                S0_BREADY,
    input  logic [ID_W-1:0]     S0_ARID,
    input  logic [ADDR_W-1:0]   S0_ARADDR,
    input  logic [7:0]          S0_ARLEN,
    input  logic [2:0]          S0_ARSIZE,
    input  logic [1:0]          S0_ARBURST,
    input  logic                S0_ARVALID,
    output logic                S0_ARREADY,
    output logic [ID_W-1:0]     S0_RID,
    output logic [DATA_W-1:0]   S0_RDATA,
    output logic [1:0]          S0_RRESP,
    output logic                S0_RLAST,
    output logic                S0_RVALID,
    input  logic                S0_RREADY,
    // master 1
    input  logic [ID_W-1:0]     S1_AWID,
    input  logic [ADDR_W-1:0]   S1_AWADDR,
    input  logic [7:0]          S1_AWLEN,
    input  logic [2:0]          S1_AWSIZE,
    input  logic [1:0]          S1_AWBURST,
    input  logic                S1_AWVALID,
    output logic                S1_AWREADY,
    input  logic [DATA_W-1:0]   S1_WDATA,
    input  logic [DATA_W/8-1:0] S1_WSTRB,
    input  logic                S1_WLAST,
    input  logic                S1_WVALID,
    output logic                S1_WREADY,
    output logic [ID_W-1:0]     S1_BID,
    output logic [1:0]          S1_BRESP,
    output logic                S1_BVALID,
    input  logic                S1_BREADY,
    input  logic [ID_W-1:0]     S1_ARID,
    input  logic [ADDR_W-1:0]   S1_ARADDR,
    input  logic [7:0]          S1_ARLEN,
    input  logic [2:0]          S1_ARSIZE,
    input  logic [1:0]          S1_ARBURST,
    input  logic                S1_ARVALID,
    output logic                S1_ARREADY,
    output logic [ID_W-1:0]     S1_RID,
    output logic [DATA_W-1:0]   S1_RDATA,
    output logic [1:0]          S1_RRESP,
    output logic                S1_RLAST,
    output logic                S1_RVALID,
    input  logic                S1_RREADY,
    // shared slave port
    output logic [ID_W-1:0]     M_AWID,
    output logic [ADDR_W-1:0]   M_AWADDR,
    output logic [7:0]          M_AWLEN,
    output logic [2:0]          M_AWSIZE,
    output logic [1:0]          M_AWBURST,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    output logic                M_WLAST,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    input  logic [ID_W-1:0]     M_BID,
    input  logic [1:0]          M_BRESP,
    input  logic                M_BVALID,
    output logic                M_BREADY,
    output logic [ID_W-1:0]     M_ARID,
    output logic [ADDR_W-1:0]   M_ARADDR,
    output logic [7:0]          M_ARLEN,
    output logic [2:0]          M_ARSIZE,
    output logic [1:0]          M_ARBURST,
    output logic                M_ARVALID,
    input  logic                M_ARREADY,
    input  logic [ID_W-1:0]     M_RID,
    input  logic [DATA_W-1:0]   M_RDATA,
    input  logic [1:0]          M_RRESP,
    input  logic                M_RLAST,
    input  logic                M_RVALID,
    output logic                M_RREADY
);

    wr_state_t wr_state_r, wr_state_nxt_s;
    rd_state_t rd_state_r, rd_state_nxt_s;
    logic      wgnt_r, wgnt_nxt_s, wpick_s, wlast_served_r, wlast_served_nxt_s;
    logic      rgnt_r, rgnt_nxt_s, rpick_s, rlast_served_r, rlast_served_nxt_s;

    axi_rr_grant u_wr_grant (
        .req         ({S1_AWVALID, S0_AWVALID}),
        .last_served (wlast_served_r),
        .gnt         (wpick_s)
    );

    axi_rr_grant u_rd_grant (
        .req         ({S1_ARVALID, S0_ARVALID}),
        .last_served (rlast_served_r),
        .gnt         (rpick_s)
    );

    // Write path: next state and grant-steered AW/W/B muxes, silent outside the active phase
    always_comb begin
        wr_state_nxt_s     = wr_state_r;
        wgnt_nxt_s         = wgnt_r;
        wlast_served_nxt_s = wlast_served_r;
        M_AWID = '0;  M_AWADDR = '0;  M_AWLEN = 8'd0;  M_AWSIZE = 3'd0;  M_AWBURST = 2'd0;
        M_AWVALID = 1'b0;
        M_WDATA = '0;  M_WSTRB = '0;  M_WLAST = 1'b0;  M_WVALID = 1'b0;  M_BREADY = 1'b0;
        S0_AWREADY = 1'b0;  S0_WREADY = 1'b0;  S0_BID = '0;  S0_BRESP = 2'd0;  S0_BVALID = 1'b0;
        S1_AWREADY = 1'b0;  S1_WREADY = 1'b0;  S1_BID = '0;  S1_BRESP = 2'd0;  S1_BVALID = 1'b0;
        case (wr_state_r)
            WR_IDLE: begin
                if (S0_AWVALID || S1_AWVALID) begin
                    wgnt_nxt_s     = wpick_s;
                    wr_state_nxt_s = WR_ADDR;
                end else begin
                    wr_state_nxt_s = WR_IDLE;
                end
            end
            WR_ADDR: begin
                if (wgnt_r) begin
                    M_AWID = S1_AWID;  M_AWADDR = S1_AWADDR;  M_AWLEN = S1_AWLEN;
                    M_AWSIZE = S1_AWSIZE;  M_AWBURST = S1_AWBURST;  M_AWVALID = S1_AWVALID;
                    S1_AWREADY = M_AWREADY;
                end else begin
                    M_AWID = S0_AWID;  M_AWADDR = S0_AWADDR;  M_AWLEN = S0_AWLEN;
                    M_AWSIZE = S0_AWSIZE;  M_AWBURST = S0_AWBURST;  M_AWVALID = S0_AWVALID;
                    S0_AWREADY = M_AWREADY;
                end
                if (M_AWVALID && M_AWREADY) begin
                    wr_state_nxt_s = WR_DATA;
                end else begin
                    wr_state_nxt_s = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (wgnt_r) begin
                    M_WDATA = S1_WDATA;  M_WSTRB = S1_WSTRB;  M_WLAST = S1_WLAST;
                    M_WVALID = S1_WVALID;  S1_WREADY = M_WREADY;
                end else begin
                    M_WDATA = S0_WDATA;  M_WSTRB = S0_WSTRB;  M_WLAST = S0_WLAST;
                    M_WVALID = S0_WVALID;  S0_WREADY = M_WREADY;
                end
                if (M_WVALID && M_WREADY && M_WLAST) begin
                    wr_state_nxt_s = WR_RESP;
                end else begin
                    wr_state_nxt_s = WR_DATA;
                end
            end
            WR_RESP: begin
                if (wgnt_r) begin
                    S1_BID = M_BID;  S1_BRESP = M_BRESP;  S1_BVALID = M_BVALID;  M_BREADY = S1_BREADY;
                end else begin
                    S0_BID = M_BID;  S0_BRESP = M_BRESP;  S0_BVALID = M_BVALID;  M_BREADY = S0_BREADY;
                end
                if (M_BVALID && M_BREADY) begin
                    wr_state_nxt_s     = WR_IDLE;
                    wlast_served_nxt_s = wgnt_r;
                end else begin
                    wr_state_nxt_s = WR_RESP;
                end
            end
            default: wr_state_nxt_s = WR_IDLE;
        endcase
    end

    // Read path: next state and grant-steered AR/R muxes, silent outside the active phase
    always_comb begin
        rd_state_nxt_s     = rd_state_r;
        rgnt_nxt_s         = rgnt_r;
        rlast_served_nxt_s = rlast_served_r;
        M_ARID = '0;  M_ARADDR = '0;  M_ARLEN = 8'd0;  M_ARSIZE = 3'd0;  M_ARBURST = 2'd0;
        M_ARVALID = 1'b0;  M_RREADY = 1'b0;
        S0_ARREADY = 1'b0;  S0_RID = '0;  S0_RDATA = '0;  S0_RRESP = 2'd0;  S0_RLAST = 1'b0;
        S0_RVALID = 1'b0;
        S1_ARREADY = 1'b0;  S1_RID = '0;  S1_RDATA = '0;  S1_RRESP = 2'd0;  S1_RLAST = 1'b0;
        S1_RVALID = 1'b0;
        case (rd_state_r)
            RD_IDLE: begin
                if (S0_ARVALID || S1_ARVALID) begin
                    rgnt_nxt_s     = rpick_s;
                    rd_state_nxt_s = RD_ADDR;
                end else begin
                    rd_state_nxt_s = RD_IDLE;
                end
            end
            RD_ADDR: begin
                if (rgnt_r) begin
                    M_ARID = S1_ARID;  M_ARADDR = S1_ARADDR;  M_ARLEN = S1_ARLEN;
                    M_ARSIZE = S1_ARSIZE;  M_ARBURST = S1_ARBURST;  M_ARVALID = S1_ARVALID;
                    S1_ARREADY = M_ARREADY;
                end else begin
                    M_ARID = S0_ARID;  M_ARADDR = S0_ARADDR;  M_ARLEN = S0_ARLEN;
                    M_ARSIZE = S0_ARSIZE;  M_ARBURST = S0_ARBURST;  M_ARVALID = S0_ARVALID;
                    S0_ARREADY = M_ARREADY;
                end
                if (M_ARVALID && M_ARREADY) begin
                    rd_state_nxt_s = RD_DATA;
                end else begin
                    rd_state_nxt_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rgnt_r) begin
                    S1_RID = M_RID;  S1_RDATA = M_RDATA;  S1_RRESP = M_RRESP;  S1_RLAST = M_RLAST;
                    S1_RVALID = M_RVALID;  M_RREADY = S1_RREADY;
                end else begin
                    S0_RID = M_RID;  S0_RDATA = M_RDATA;  S0_RRESP = M_RRESP;  S0_RLAST = M_RLAST;
                    S0_RVALID = M_RVALID;  M_RREADY = S0_RREADY;
                end
                if (M_RVALID && M_RREADY && M_RLAST) begin
                    rd_state_nxt_s     = RD_IDLE;
                    rlast_served_nxt_s = rgnt_r;
                end else begin
                    rd_state_nxt_s = RD_DATA;
                end
            end
            default: rd_state_nxt_s = RD_IDLE;
        endcase
    end

    // Path state, burst-locked grants and round-robin history; last_served=1 lets master 0 win the first tie
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state_r     <= WR_IDLE;
            wgnt_r         <= 1'b0;
            wlast_served_r <= 1'b1;
            rd_state_r     <= RD_IDLE;
            rgnt_r         <= 1'b0;
            rlast_served_r <= 1'b1;
        end else begin
            wr_state_r     <= wr_state_nxt_s;
            wgnt_r         <= wgnt_nxt_s;
            wlast_served_r <= wlast_served_nxt_s;
            rd_state_r     <= rd_state_nxt_s;
            rgnt_r         <= rgnt_nxt_s;
            rlast_served_r <= rlast_served_nxt_s;
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter_2to1.sv
// Self-checking bench for axi_rr_arbiter_2to1: directed scenarios plus randomized rounds,
// with a bench-side round-robin model and a scripted slave on the shared port.
module tb_axi_rr_arbiter_2to1;
    import axi_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    logic [1:0][ID_W-1:0]   s_awid, s_arid;
    logic [1:0][ADDR_W-1:0] s_awaddr, s_araddr;
    logic [1:0][7:0]        s_awlen, s_arlen;
    logic [1:0][2:0]        s_awsize, s_arsize;
    logic [1:0][1:0]        s_awburst, s_arburst;
    logic [1:0]             s_awvalid, s_arvalid, s_wvalid, s_wlast, s_bready, s_rready;
    logic [1:0][DATA_W-1:0] s_wdata;
    logic [1:0][3:0]        s_wstrb;
    wire  [1:0]             s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
    wire  [1:0][ID_W-1:0]   s_bid, s_rid;
    wire  [1:0][1:0]        s_bresp, s_rresp;
    wire  [1:0][DATA_W-1:0] s_rdata;

    wire  [ID_W-1:0]   m_awid, m_arid;
    wire  [ADDR_W-1:0] m_awaddr, m_araddr;
    wire  [7:0]        m_awlen, m_arlen;
    wire  [2:0]        m_awsize, m_arsize;
    wire  [1:0]        m_awburst, m_arburst;
    wire               m_awvalid, m_arvalid, m_wvalid, m_wlast, m_bready, m_rready;
    wire  [DATA_W-1:0] m_wdata;
    wire  [3:0]        m_wstrb;
    logic              m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_rlast;
    logic [ID_W-1:0]   m_bid, m_rid;
    logic [1:0]        m_bresp, m_rresp;
    logic [DATA_W-1:0] m_rdata;

    axi_rr_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .S0_AWID(s_awid[0]), .S0_AWADDR(s_awaddr[0]), .S0_AWLEN(s_awlen[0]), .S0_AWSIZE(s_awsize[0]),
        .S0_AWBURST(s_awburst[0]), .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
        .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WLAST(s_wlast[0]), .S0_WVALID(s_wvalid[0]),
        .S0_WREADY(s_wready[0]), .S0_BID(s_bid[0]), .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]),
        .S0_BREADY(s_bready[0]),
        .S0_ARID(s_arid[0]), .S0_ARADDR(s_araddr[0]), .S0_ARLEN(s_arlen[0]), .S0_ARSIZE(s_arsize[0]),
        .S0_ARBURST(s_arburst[0]), .S0_ARVALID(s_arvalid[0]), .S0_ARREADY(s_arready[0]),
        .S0_RID(s_rid[0]), .S0_RDATA(s_rdata[0]), .S0_RRESP(s_rresp[0]), .S0_RLAST(s_rlast[0]),
        .S0_RVALID(s_rvalid[0]), .S0_RREADY(s_rready[0]),
        .S1_AWID(s_awid[1]), .S1_AWADDR(s_awaddr[1]), .S1_AWLEN(s_awlen[1]), .S1_AWSIZE(s_awsize[1]),
        .S1_AWBURST(s_awburst[1]), .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
        .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WLAST(s_wlast[1]), .S1_WVALID(s_wvalid[1]),
        .S1_WREADY(s_wready[1]), .S1_BID(s_bid[1]), .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]),
        .S1_BREADY(s_bready[1]),
        .S1_ARID(s_arid[1]), .S1_ARADDR(s_araddr[1]), .S1_ARLEN(s_arlen[1]), .S1_ARSIZE(s_arsize[1]),
        .S1_ARBURST(s_arburst[1]), .S1_ARVALID(s_arvalid[1]), .S1_ARREADY(s_arready[1]),
        .S1_RID(s_rid[1]), .S1_RDATA(s_rdata[1]), .S1_RRESP(s_rresp[1]), .S1_RLAST(s_rlast[1]),
        .S1_RVALID(s_rvalid[1]), .S1_RREADY(s_rready[1]),
        .M_AWID(m_awid), .M_AWADDR(m_awaddr), .M_AWLEN(m_awlen), .M_AWSIZE(m_awsize),
        .M_AWBURST(m_awburst), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WLAST(m_wlast), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
        .M_BID(m_bid), .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .M_ARID(m_arid), .M_ARADDR(m_araddr), .M_ARLEN(m_arlen), .M_ARSIZE(m_arsize),
        .M_ARBURST(m_arburst), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
        .M_RID(m_rid), .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RLAST(m_rlast), .M_RVALID(m_rvalid),
        .M_RREADY(m_rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending burst contents per master and round-robin history per path
    logic [DATA_W-1:0] wbeat [2][16];
    logic [ID_W-1:0]   wid [2], rid_x [2];
    logic [ADDR_W-1:0] waddr [2], raddr [2];
    int                wlen [2], rlen [2];
    int                wls_model, rls_model;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1, input int ls);
        if (r0 && r1) return 1 - ls;
        else if (r1) return 1;
        else return 0;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_vr"}, {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_awready, s_wready,
                           s_bvalid, s_arready, s_rvalid}, 64'd0);
        chk({tag, "_data"}, {m_awaddr, m_wdata}, 64'd0);
        chk({tag, "_resp"}, {s_rdata[0], s_rdata[1]}, 64'd0);
    endtask

    task automatic post_aw(input int m, input int len, input bit fixed);
        logic [31:0] r;
        logic        mb;
        r  = $urandom();
        mb = m[0];
        wid[m]        = ID_W'($urandom_range(0, 3));
        waddr[m]      = fixed ? 32'h0000_0010 : {mb, r[30:0]};
        wlen[m]       = len;
        s_awid[m]     = wid[m];
        s_awaddr[m]   = waddr[m];
        s_awlen[m]    = 8'(len);
        s_awsize[m]   = 3'd2;
        s_awburst[m]  = 2'd1;
        s_awvalid[m]  = 1'b1;
        for (int b = 0; b <= len; b++) wbeat[m][b] = fixed ? 32'h0000_00A0 + 32'(b) : 32'($urandom());
        s_wvalid[m] = 1'b1;
        s_wdata[m]  = wbeat[m][0];
        s_wlast[m]  = (len == 0);
        s_wstrb[m]  = 4'hF;
    endtask

    task automatic post_ar(input int m, input int len);
        logic [31:0] r;
        logic        mb;
        r  = $urandom();
        mb = m[0];
        rid_x[m]     = ID_W'($urandom_range(0, 3));
        raddr[m]     = {mb, r[30:0]};
        rlen[m]      = len;
        s_arid[m]    = rid_x[m];
        s_araddr[m]  = raddr[m];
        s_arlen[m]   = 8'(len);
        s_arsize[m]  = 3'd2;
        s_arburst[m] = 2'd1;
        s_arvalid[m] = 1'b1;
    endtask

    // One write burst for the master the model expects to win; abort_beat >= 0 pulses reset there
    task automatic serve_write(input int abort_beat, input bit rnd);
        int g, o, k;
        logic [ID_W-1:0] saw_id;
        logic [1:0]      resp;
        g = pick(s_awvalid[0], s_awvalid[1], wls_model);
        o = 1 - g;
        m_awready = 1'b0;
        tick();
        chk("aw_latency", m_awvalid, 1);
        chk("aw_id", m_awid, wid[g]);
        chk("aw_addr", m_awaddr, waddr[g]);
        chk("aw_len", m_awlen, wlen[g]);
        chk("w_before_data", {m_wvalid, s_wready}, 0);
        k = rnd ? $urandom_range(0, 2) : 0;
        repeat (k) begin
            chk("awready_hold", s_awready[g], 0);
            tick();
            chk("awvalid_hold", m_awvalid, 1);
        end
        m_awready = 1'b1;
        #1;
        chk("awready_route", {s_awready[o], s_awready[g]}, 2'b01);
        saw_id = m_awid;
        tick();
        s_awvalid[g] = 1'b0;
        m_awready    = 1'b0;
        for (int b = 0; b <= wlen[g]; b++) begin
            s_wvalid[g] = 1'b1;
            s_wdata[g]  = wbeat[g][b];
            s_wlast[g]  = (b == wlen[g]);
            s_wstrb[g]  = rnd ? 4'($urandom()) : 4'hF;
            if (b == abort_beat) begin
                m_wready = 1'b1;
                ARESETn  = 1'b0;
                #1;
                chk_quiet("reset_mid_burst");
                return;
            end
            k = rnd ? $urandom_range(0, 1) : 0;
            repeat (k) begin
                m_wready = 1'b0;
                #1;
                chk("wready_stall", {m_wvalid, s_wready[g]}, 2'b10);
                tick();
            end
            m_wready = 1'b1;
            #1;
            chk("w_data", m_wdata, wbeat[g][b]);
            chk("w_last_strb", {m_wlast, m_wstrb}, {s_wlast[g], s_wstrb[g]});
            chk("wready_route", {s_wready[o], s_wready[g], m_wvalid}, 3'b011);
            tick();
        end
        s_wvalid[g] = 1'b0;
        s_wlast[g]  = 1'b0;
        m_wready    = 1'b0;
        resp        = rnd && $urandom_range(0, 1) == 1 ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        m_bvalid    = 1'b1;
        m_bid       = saw_id;
        m_bresp     = resp;
        k = rnd ? $urandom_range(0, 2) : 0;
        repeat (k) begin
            s_bready[g] = 1'b0;
            #1;
            chk("bready_stall", {m_bready, s_bvalid[g], s_bvalid[o]}, 3'b010);
            tick();
        end
        s_bready[g] = 1'b1;
        #1;
        chk("b_route", {m_bready, s_bvalid[g], s_bvalid[o]}, 3'b110);
        chk("b_id_resp", {s_bid[g], s_bresp[g]}, {wid[g], resp});
        chk("b_other_id", s_bid[o], 0);
        tick();
        s_bready[g] = 1'b0;
        m_bvalid    = 1'b0;
        wls_model   = g;
        #1;
        chk("wr_idle_gap", {m_awvalid, m_wvalid, m_bready}, 3'b000);
    endtask

    // One read burst; stall_beat holds the winner's RREADY low for stall_len cycles on that beat
    task automatic serve_read(input int stall_beat, input int stall_len, input bit rnd, output int cycles);
        int g, o, k;
        logic [ID_W-1:0]   saw_id;
        logic [DATA_W-1:0] d;
        logic [1:0]        rr;
        g = pick(s_arvalid[0], s_arvalid[1], rls_model);
        o = 1 - g;
        cycles    = 0;
        m_arready = 1'b0;
        tick();
        cycles++;
        chk("ar_latency", m_arvalid, 1);
        chk("ar_id_addr", {m_arid, m_araddr}, {rid_x[g], raddr[g]});
        chk("ar_len", m_arlen, rlen[g]);
        k = rnd ? $urandom_range(0, 2) : 0;
        repeat (k) begin
            chk("arready_hold", s_arready[g], 0);
            tick();
            cycles++;
        end
        m_arready = 1'b1;
        #1;
        chk("arready_route", {s_arready[o], s_arready[g]}, 2'b01);
        saw_id = m_arid;
        tick();
        cycles++;
        s_arvalid[g] = 1'b0;
        m_arready    = 1'b0;
        for (int b = 0; b <= rlen[g]; b++) begin
            d  = $urandom();
            rr = rnd && $urandom_range(0, 3) == 0 ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            m_rvalid = 1'b1;
            m_rdata  = d;
            m_rresp  = rr;
            m_rid    = saw_id;
            m_rlast  = (b == rlen[g]);
            k = (b == stall_beat) ? stall_len : (rnd ? $urandom_range(0, 1) : 0);
            repeat (k) begin
                s_rready[g] = 1'b0;
                #1;
                chk("rready_stall", {m_rready, s_rvalid[g], s_rvalid[o]}, 3'b010);
                chk("r_held_data", s_rdata[g], d);
                tick();
                cycles++;
            end
            s_rready[g] = 1'b1;
            #1;
            chk("r_route", {m_rready, s_rvalid[g], s_rvalid[o], s_rlast[o]}, 4'b1100);
            chk("r_data", s_rdata[g], d);
            chk("r_id_resp_last", {s_rid[g], s_rresp[g], s_rlast[g]}, {rid_x[g], rr, b == rlen[g]});
            tick();
            cycles++;
        end
        s_rready[g] = 1'b0;
        m_rvalid    = 1'b0;
        m_rlast     = 1'b0;
        rls_model   = g;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        ARESETn = 1'b0;
        s_awid = '0;  s_awaddr = '0;  s_awlen = '0;  s_awsize = '0;  s_awburst = '0;  s_awvalid = '0;
        s_arid = '0;  s_araddr = '0;  s_arlen = '0;  s_arsize = '0;  s_arburst = '0;  s_arvalid = '0;
        s_wdata = '0;  s_wstrb = '0;  s_wlast = '0;  s_wvalid = '0;  s_bready = '0;  s_rready = '0;
        m_awready = 1'b0;  m_wready = 1'b0;  m_arready = 1'b0;  m_bvalid = 1'b0;  m_rvalid = 1'b0;
        m_rlast = 1'b0;  m_bid = '0;  m_rid = '0;  m_bresp = 2'd0;  m_rresp = 2'd0;  m_rdata = '0;
        wls_model = 1;
        rls_model = 1;
        #3;
        chk_quiet("reset_state");
        repeat (2) tick();
        ARESETn = 1'b1;
        tick();
        chk_quiet("post_reset_idle");

        // tie straight after reset: master 0 first, master 1 on the following IDLE
        post_aw(0, 1, 1'b0);
        post_aw(1, 2, 1'b0);
        serve_write(-1, 1'b0);
        serve_write(-1, 1'b0);

        // three contended rounds, re-requesting the winner each time
        post_aw(0, 1, 1'b0);
        post_aw(1, 0, 1'b0);
        serve_write(-1, 1'b1);
        post_aw(0, 2, 1'b0);
        serve_write(-1, 1'b1);
        post_aw(1, 1, 1'b0);
        serve_write(-1, 1'b1);
        serve_write(-1, 1'b1);

        // master 0 alone: address 0x10, 4 beats 0xA0..0xA3
        post_aw(0, 3, 1'b1);
        serve_write(-1, 1'b0);

        // isolated read then the same read alongside a write
        post_ar(1, 1);
        serve_read(-1, 0, 1'b0, cyc);
        chk("rd_cycles_isolated", cyc, 4);
        post_aw(0, 3, 1'b0);
        post_ar(1, 1);
        fork
            serve_write(-1, 1'b0);
            serve_read(-1, 0, 1'b0, cyc);
        join
        chk("rd_cycles_concurrent", cyc, 4);

        // master 1 stalls RREADY for 3 cycles mid-burst
        post_ar(1, 3);
        serve_read(1, 3, 1'b0, cyc);
        chk("rd_cycles_stalled", cyc, 9);

        // randomized rounds on both paths
        for (int i = 0; i < 24; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!s_awvalid[m] && $urandom_range(0, 1) == 1) post_aw(m, $urandom_range(0, 5), 1'b0);
                if (!s_arvalid[m] && $urandom_range(0, 1) == 1) post_ar(m, $urandom_range(0, 5));
            end
            fork
                begin
                    if (s_awvalid != 2'b00) serve_write(-1, 1'b1);
                end
                begin
                    if (s_arvalid != 2'b00) serve_read(-1, 0, 1'b1, cyc);
                end
            join
        end
        for (int i = 0; i < 2; i++) begin
            if (s_awvalid != 2'b00) serve_write(-1, 1'b1);
            if (s_arvalid != 2'b00) serve_read(-1, 0, 1'b1, cyc);
        end

        // reset pulsed on beat 2 of 4, then a solo master 1 request
        post_aw(0, 3, 1'b0);
        serve_write(1, 1'b0);
        s_awvalid = '0;  s_wvalid = '0;  s_wlast = '0;  s_arvalid = '0;
        m_wready = 1'b0;  m_awready = 1'b0;
        tick();
        chk_quiet("reset_held");
        ARESETn   = 1'b1;
        wls_model = 1;
        rls_model = 1;
        tick();
        post_aw(1, 2, 1'b0);
        serve_write(-1, 1'b0);
        post_aw(0, 0, 1'b0);
        post_aw(1, 0, 1'b0);
        serve_write(-1, 1'b0);
        serve_write(-1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
